// File: rtl/fifo_share_ctrl_if.sv
// Producer request/grant and consumer stream signals of fifo_share_ctrl.
// The slave side is the controller. The master side is the producers and the sink.
interface fifo_share_ctrl_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       gnt;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic [IDW-1:0]         out_src;
   logic                   out_ready;

   modport slave (
      input  req, req_data, out_ready,
      output gnt, out_valid, out_data, out_src
   );

   modport master (
      output req, req_data, out_ready,
      input  gnt, out_valid, out_data, out_src
   );
endinterface

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin write arbiter and read sequencer for a shared
// synchronous FIFO. The FIFO has one-cycle registered read data. Each entry is
// tagged with its source index, and the FIFO drains into a 2-entry output buffer.
module fifo_share_ctrl #(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 8,
   localparam int IDW   = $clog2(N_REQ),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_share_ctrl_if.slave     bus,
   output logic                 fifo_wen,
   output logic [IDW+WIDTH-1:0] fifo_wdata,
   output logic                 fifo_ren,
   input  logic [IDW+WIDTH-1:0] fifo_rdata,
   output logic [LW-1:0]        level
);
   localparam int             EW       = IDW + WIDTH;
   localparam logic [LW-1:0]  DEPTH_L  = LW'(DEPTH);
   localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(N_REQ);
   localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

   // State
   logic [LW-1:0]  level_reg, level_next;
   logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
   logic           inflight_reg;
   logic [1:0]     ob_cnt_reg, ob_cnt_next;
   logic [EW-1:0]  head_reg, head_next;
   logic [EW-1:0]  tail_reg, tail_next;

   // Arbitration and sequencing signals
   logic [WIDTH-1:0] req_word [N_REQ];
   logic [IDW:0]     cand;
   logic             gnt_any;
   logic [IDW-1:0]   gnt_idx;
   logic [N_REQ-1:0] gnt_vec;
   logic             out_valid_int;
   logic             pop;
   logic [2:0]       occ;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Pick the first requester at or after rr_ptr, but only while the FIFO has room.
   // rst_n is included so that no grant leaks out during reset.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (rst_n && (level_reg < DEPTH_L)) begin
         for (int j = 0; j < N_REQ; j++) begin
            cand = {1'b0, rr_ptr_reg} + (IDW + 1)'(j);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!gnt_any && bus.req[cand[IDW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = cand[IDW-1:0];
            end
         end
      end
   end

   // Expand the winning index into the one-hot grant vector.
   always_comb begin
      gnt_vec          = '0;
      gnt_vec[gnt_idx] = gnt_any;
   end

   assign bus.gnt    = gnt_vec;
   assign fifo_wen   = gnt_any;
   assign fifo_wdata = {gnt_idx, req_word[gnt_idx]};

   // Issue a read only if the returning word is guaranteed a buffer slot.
   assign out_valid_int = (ob_cnt_reg != 2'd0);
   assign pop           = out_valid_int & bus.out_ready;
   assign occ           = {1'b0, ob_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign fifo_ren      = (level_reg != '0) & (occ < 3'd2);

   assign level_next  = level_reg + LW'(fifo_wen) - LW'(fifo_ren);
   assign rr_ptr_next = !gnt_any ? rr_ptr_reg :
                        (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);

   // Output buffer update: shift on pop, then land returning FIFO data in the first free slot.
   always_comb begin
      head_next   = head_reg;
      tail_next   = tail_reg;
      ob_cnt_next = ob_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
      if (pop) head_next = tail_reg;
      if (inflight_reg) begin
         if ((ob_cnt_reg == 2'd0) || ((ob_cnt_reg == 2'd1) && pop))
            head_next = fifo_rdata;
         else
            tail_next = fifo_rdata;
      end
   end

   // State registers. Reset discards everything, including a read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg    <= '0;
         rr_ptr_reg   <= '0;
         inflight_reg <= 1'b0;
         ob_cnt_reg   <= 2'd0;
         head_reg     <= '0;
         tail_reg     <= '0;
      end else begin
         level_reg    <= level_next;
         rr_ptr_reg   <= rr_ptr_next;
         inflight_reg <= fifo_ren;
         ob_cnt_reg   <= ob_cnt_next;
         head_reg     <= head_next;
         tail_reg     <= tail_next;
      end
   end

   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = head_reg[WIDTH-1:0];
   assign bus.out_src   = head_reg[EW-1:WIDTH];
   assign level         = level_reg;
endmodule
